// File: rtl/scramble_pkg.sv
// Shared constants and types for the frame-synchronous scrambler key scheduler.
package scramble_pkg;

  localparam int KEY_W         = 24;
  localparam int IDX_W         = 6;
  localparam int FRAME_LEN_DEF = 64;

  // Taps 23, 22, 21, 16 give a maximal-length 24-bit sequence.
  localparam logic [KEY_W-1:0] LFSR_TAPS  = 24'hE10000;
  localparam logic [KEY_W-1:0] SEED_SUBST = 24'h000001;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } sched_state_e;

endpackage

// File: rtl/lfsr24_step.sv
// One step of the left-shifting Fibonacci LFSR; shared by transmit and receive schedulers.
module lfsr24_step
  import scramble_pkg::*;
(
  input  logic [KEY_W-1:0] state_i,
  output logic [KEY_W-1:0] next_o
);

  assign next_o = {state_i[KEY_W-2:0], ^(state_i & LFSR_TAPS)};

endmodule

// File: rtl/scramble_key_scheduler.sv
// Produces a per-frame scrambler key from a seeded LFSR, advancing on di_en strobes
// and installing a new key on the last sample of each frame.
module scramble_key_scheduler
  import scramble_pkg::*;
#(
  parameter int FRAME_LEN       = FRAME_LEN_DEF,
  parameter int STEPS_PER_FRAME = 24
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             di_en_i,
  input  logic             seed_load_i,
  input  logic [KEY_W-1:0] seed_i,
  input  logic             scramble_on_i,
  output logic [KEY_W-1:0] shift_key_o,
  output logic             key_valid_o,
  output logic             frame_start_o,
  output logic [IDX_W-1:0] sample_idx_o
);

  localparam int                LAST_INT  = FRAME_LEN - 1;
  localparam logic [IDX_W-1:0]  IDX_LAST  = LAST_INT[IDX_W-1:0];
  localparam logic [IDX_W:0]    STEPS_CMP = STEPS_PER_FRAME[IDX_W:0];

  sched_state_e     state_q, state_d;
  logic [KEY_W-1:0] lfsr_q, lfsr_d, lfsr_next;
  logic [KEY_W-1:0] key_q, key_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             fstart_q, fstart_d;
  logic             step_en;

  lfsr24_step u_step (
    .state_i (lfsr_q),
    .next_o  (lfsr_next)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      lfsr_q   <= SEED_SUBST;
      key_q    <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      fstart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      key_q    <= key_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      fstart_q <= fstart_d;
    end
  end

  // A seed load outranks a same-cycle strobe; that sample is not counted.
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    key_d    = key_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    fstart_d = 1'b0;
    step_en  = 1'b0;

    if (seed_load_i) begin
      lfsr_d  = (seed_i == '0) ? SEED_SUBST : seed_i;
      idx_d   = '0;
      key_d   = '0;
      valid_d = 1'b0;
      state_d = ST_RUN;
    end else if (state_q == ST_RUN && di_en_i) begin
      step_en = ({1'b0, idx_q} < STEPS_CMP);
      if (step_en) begin
        lfsr_d = lfsr_next;
      end
      // The LFSR keeps stepping in bypass so a receiver stays in sequence.
      if (idx_q == IDX_LAST) begin
        key_d    = scramble_on_i ? lfsr_d : '0;
        valid_d  = 1'b1;
        fstart_d = 1'b1;
        idx_d    = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  assign shift_key_o   = key_q;
  assign key_valid_o   = valid_q;
  assign frame_start_o = fstart_q;
  assign sample_idx_o  = idx_q;

endmodule

// File: tb/tb_scramble_key_scheduler.sv
// Scoreboard bench for scramble_key_scheduler: a reference model pushes expected
// outputs per driven cycle, each test pops and compares after the clock edge.
module tb_scramble_key_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        diEn = 1'b0;
  logic        seedLoad = 1'b0;
  logic        scrambleOn = 1'b0;
  logic [23:0] seed = '0;
  logic [23:0] shiftKey;
  logic        keyValid;
  logic        frameStart;
  logic [5:0]  sampleIdx;

  typedef struct packed {
    logic [23:0] key;
    logic        valid;
    logic        fs;
    logic [5:0]  idx;
  } obs_t;

  obs_t sb[$];
  obs_t expO;
  obs_t actO;
  int   total = 0;
  int   bad = 0;

  logic [23:0] mLfsr = 24'h000001;
  logic [23:0] mKey = '0;
  logic [5:0]  mIdx = '0;
  logic        mValid = 1'b0;
  logic        mFs = 1'b0;
  logic        mRun = 1'b0;

  scramble_key_scheduler #(
    .FRAME_LEN       (64),
    .STEPS_PER_FRAME (24)
  ) dut (
    .clock_i       (clock),
    .reset_i       (reset),
    .di_en_i       (diEn),
    .seed_load_i   (seedLoad),
    .seed_i        (seed),
    .scramble_on_i (scrambleOn),
    .shift_key_o   (shiftKey),
    .key_valid_o   (keyValid),
    .frame_start_o (frameStart),
    .sample_idx_o  (sampleIdx)
  );

  always #5 clock = ~clock;

  function automatic logic [23:0] refStep(input logic [23:0] s);
    return {s[22:0], s[23] ^ s[22] ^ s[21] ^ s[16]};
  endfunction

  function automatic logic [23:0] refKeyAfter(input logic [23:0] s, input int frames);
    logic [23:0] v;
    v = (s == 24'h0) ? 24'h000001 : s;
    for (int i = 0; i < frames * 24; i++) v = refStep(v);
    return v;
  endfunction

  // Drives one cycle at the falling edge, advances the model, and captures the
  // DUT outputs just after the following rising edge.
  task automatic applyStimulus(input logic rst, input logic load, input logic en,
                               input logic son, input logic [23:0] sd);
    @(negedge clock);
    reset = rst; seedLoad = load; diEn = en; scrambleOn = son; seed = sd;
    mFs = 1'b0;
    if (rst) begin
      mLfsr = 24'h000001; mIdx = '0; mKey = '0; mValid = 1'b0; mRun = 1'b0;
    end else if (load) begin
      mLfsr = (sd == 24'h0) ? 24'h000001 : sd;
      mIdx = '0; mKey = '0; mValid = 1'b0; mRun = 1'b1;
    end else if (mRun && en) begin
      if (mIdx < 6'd24) mLfsr = refStep(mLfsr);
      if (mIdx == 6'd63) begin
        mKey = son ? mLfsr : 24'h0; mValid = 1'b1; mFs = 1'b1; mIdx = '0;
      end else begin
        mIdx = mIdx + 6'd1;
      end
    end
    sb.push_back('{mKey, mValid, mFs, mIdx});
    @(posedge clock);
    #1;
    actO = '{shiftKey, keyValid, frameStart, sampleIdx};
  endtask

  task automatic test_reset();
    applyStimulus(1, 0, 0, 0, 24'h0);
    applyStimulus(1, 1, 1, 1, 24'h00BEEF);
    expO = sb.pop_front();
    expO = sb.pop_front();
    total++;
    if (actO !== 37'h0) begin
      bad++; $display("[TB] FAIL reset_values got=%h want=%h", actO, 37'h0);
    end
    total++;
    if (actO !== expO) begin
      bad++; $display("[TB] FAIL reset_model got=%h want=%h", actO, expO);
    end
  endtask

  task automatic test_idle_strobes();
    int pulses = 0;
    for (int i = 0; i < 200; i++) begin
      applyStimulus(0, 0, 1, 1, 24'h0);
      expO = sb.pop_front();
      if (actO.fs === 1'b1) pulses++;
      total++;
      if (actO !== expO) begin
        bad++; $display("[TB] FAIL idle_cycle%0d got=%h want=%h", i, actO, expO);
      end
    end
    total++;
    if (pulses != 0 || actO !== 37'h0) begin
      bad++; $display("[TB] FAIL idle_quiet pulses=%0d got=%h want=0", pulses, actO);
    end
  endtask

  task automatic test_first_key(input logic [23:0] sd, input string name);
    int pulses = 0;
    applyStimulus(0, 1, 0, 1, sd);
    expO = sb.pop_front();
    for (int i = 0; i < 64; i++) begin
      applyStimulus(0, 0, 1, 1, 24'h0);
      expO = sb.pop_front();
      if (actO.fs === 1'b1) pulses++;
      total++;
      if (actO !== expO) begin
        bad++; $display("[TB] FAIL %s_cycle%0d got=%h want=%h", name, i, actO, expO);
      end
    end
    total++;
    if (actO.key !== 24'h000087 || actO.valid !== 1'b1 || actO.fs !== 1'b1 || pulses != 1) begin
      bad++;
      $display("[TB] FAIL %s_key got=%h/%b/%b pulses=%0d want=000087/1/1 pulses=1",
               name, actO.key, actO.valid, actO.fs, pulses);
    end
  endtask

  task automatic test_scramble_off();
    logic [23:0] sd = 24'h5A3C91;
    applyStimulus(0, 1, 0, 1, sd);
    expO = sb.pop_front();
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 64; i++) begin
        applyStimulus(0, 0, 1, (f == 1) ? (i < 30) : ((f == 2) ? (i >= 10) : 1'b1), 24'h0);
        expO = sb.pop_front();
        total++;
        if (actO !== expO) begin
          bad++; $display("[TB] FAIL bypass_f%0d_s%0d got=%h want=%h", f, i, actO, expO);
        end
      end
      if (f == 1) begin
        total++;
        if (actO.key !== 24'h0 || actO.valid !== 1'b1) begin
          bad++; $display("[TB] FAIL bypass_zero got=%h/%b want=000000/1", actO.key, actO.valid);
        end
      end
    end
    total++;
    if (actO.key !== refKeyAfter(sd, 3)) begin
      bad++; $display("[TB] FAIL bypass_resume got=%h want=%h", actO.key, refKeyAfter(sd, 3));
    end
  endtask

  task automatic test_load_mid_frame();
    int pulses = 0;
    applyStimulus(0, 1, 0, 1, 24'h123456);
    expO = sb.pop_front();
    for (int i = 0; i < 40; i++) begin
      applyStimulus(0, 0, 1, 1, 24'h0);
      expO = sb.pop_front();
    end
    total++;
    if (actO !== expO) begin
      bad++; $display("[TB] FAIL midload_pre got=%h want=%h", actO, expO);
    end
    applyStimulus(0, 1, 1, 1, 24'hC0FFEE);
    expO = sb.pop_front();
    total++;
    if (actO.idx !== 6'd0 || actO.key !== 24'h0 || actO.valid !== 1'b0) begin
      bad++; $display("[TB] FAIL midload_clear got=%h want idx0 key0 valid0", actO);
    end
    for (int i = 0; i < 64; i++) begin
      applyStimulus(0, 0, 1, 1, 24'h0);
      expO = sb.pop_front();
      if (actO.fs === 1'b1) pulses++;
      total++;
      if (actO !== expO) begin
        bad++; $display("[TB] FAIL midload_cycle%0d got=%h want=%h", i, actO, expO);
      end
    end
    total++;
    if (actO.fs !== 1'b1 || pulses != 1 || actO.key !== refKeyAfter(24'hC0FFEE, 1)) begin
      bad++;
      $display("[TB] FAIL midload_key got=%h fs=%b pulses=%0d want=%h fs=1 pulses=1",
               actO.key, actO.fs, pulses, refKeyAfter(24'hC0FFEE, 1));
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(0, 1, 0, 1, 24'h0F0F0F);
    expO = sb.pop_front();
    for (int i = 0; i < 400; i++) begin
      applyStimulus(0, 0, (i >= 150) ? 1'b1 : 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 3) != 0), 24'h0);
      expO = sb.pop_front();
      total++;
      if (actO !== expO) begin
        bad++; $display("[TB] FAIL b2b_cycle%0d got=%h want=%h", i, actO, expO);
      end
    end
  endtask

  task automatic test_reset_at_boundary();
    applyStimulus(0, 1, 0, 1, 24'hA5A5A5);
    expO = sb.pop_front();
    for (int i = 0; i < 63; i++) begin
      applyStimulus(0, 0, 1, 1, 24'h0);
      expO = sb.pop_front();
    end
    total++;
    if (actO.idx !== 6'd63) begin
      bad++; $display("[TB] FAIL rstb_pre idx got=%0d want=63", actO.idx);
    end
    applyStimulus(1, 0, 1, 1, 24'h0);
    expO = sb.pop_front();
    total++;
    if (actO !== 37'h0) begin
      bad++; $display("[TB] FAIL rstb_clear got=%h want=%h", actO, 37'h0);
    end
    applyStimulus(0, 0, 1, 1, 24'h0);
    expO = sb.pop_front();
    total++;
    if (actO !== expO || actO.idx !== 6'd0) begin
      bad++; $display("[TB] FAIL rstb_idle got=%h want=%h", actO, expO);
    end
  endtask

  initial begin
    $display("[TB] starting scramble_key_scheduler bench");
    test_reset();
    test_idle_strobes();
    test_first_key(24'h000001, "seed1");
    test_first_key(24'h000000, "seed0");
    test_scramble_off();
    test_load_mid_frame();
    test_back_to_back();
    test_reset_at_boundary();
    total++;
    if (sb.size() != 0) begin
      bad++; $display("[TB] FAIL scoreboard_left got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scramble_key_scheduler.md
# scramble_key_scheduler

Generates the 24-bit `shift_key` consumed by `ScramblerAudio`. The key is frame-synchronous: it changes only on 64-sample frame boundaries and is derived from a seeded 24-bit LFSR, so transmitter and receiver stay in lock-step from a shared seed. The block sits directly upstream of `ScramblerAudio`, on the same sample-rate clock and `di_en` strobe, and also exports the frame position for downstream alignment.

## Interface
- `FRAME_LEN`, default 64: samples per frame. Must equal the FFT size.
- `STEPS_PER_FRAME`, default 24: LFSR advances per frame. Must be ≤ `FRAME_LEN`.
- `clock` in 1: single master clock, equal to the sampling clock.
- `reset` in 1: synchronous, active-high.
- `di_en` in 1: sample strobe; the same signal that drives `ScramblerAudio.di_en`.
- `seed_load` in 1: one-cycle pulse; loads `seed` and restarts frame alignment.
- `seed` in 24: LFSR seed.
- `scramble_on` in 1: 0 means a zero key (bypass), applied at the next frame boundary.
- `shift_key` out 24: key for the current frame; drives `ScramblerAudio.shift_key`.
- `key_valid` out 1: 1 while `shift_key` comes from a seeded LFSR.
- `frame_start` out 1: one-cycle pulse on the edge where a new frame key is installed.
- `sample_idx` out 6: index, within the frame, of the next `di_en` sample.

## Operation
- States:
  - IDLE: after reset, no seed loaded.
  - RUN: seed loaded.
- IDLE:
  - `shift_key`=0, `key_valid`=0, counter held at 0, `di_en` ignored.
  - `seed_load` moves the block to RUN.
- `seed_load` in any state:
  - `lfsr`<=`seed`; if `seed`==0, load 24'h000001 instead (avoids the lock-up state).
  - `sample_idx`<=0, `shift_key`<=0, `key_valid`<=0, state<=RUN.
  - Takes priority over a same-cycle `di_en`; that sample is not counted.
- LFSR (Fibonacci, left shift):
  - `lfsr`<={`lfsr`[22:0], fb}, where fb = `lfsr`[23]^`lfsr`[22]^`lfsr`[21]^`lfsr`[16] (maximal length).
- RUN, on each `di_en`:
  - If `sample_idx` < `STEPS_PER_FRAME`, the LFSR steps once.
  - `sample_idx` increments and wraps from `FRAME_LEN`-1 to 0.
- Frame boundary: `di_en` with `sample_idx`==`FRAME_LEN`-1.
  - `shift_key`<= `scramble_on` ? `lfsr` : 0. The LFSR value used is its state after the 24 steps of the frame.
  - `key_valid`<=1.
  - `frame_start` pulses high for 1 cycle.
  - The LFSR keeps running regardless of `scramble_on`, so a receiver in bypass stays in sequence.
- The key installed at the end of frame N applies to samples of frame N+1.
- The first frame after `seed_load` carries a zero key.
- `scramble_on` and `seed` are sampled only at the edges stated above; mid-frame changes have no effect until then.

## Timing
- Reset values: `shift_key`=0, `key_valid`=0, `frame_start`=0, `sample_idx`=0, state=IDLE, `lfsr`=24'h000001.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `shift_key` changes only on a frame-boundary edge, a `seed_load`, or `reset`. It is stable for exactly `FRAME_LEN` `di_en` strobes.
- Frame-boundary latency: `shift_key` is updated on the same edge that accepts sample `FRAME_LEN`-1, so it is valid before the next strobe.
- No constraint on `di_en` spacing; back-to-back strobes on every cycle are legal.
- `reset` mid-frame: returns to IDLE on the next edge and discards the seed and counter.
- `reset` and `seed_load` asserted together: `reset` wins.

## Structure
- A shared package `scramble_pkg` holds:
  - `KEY_W`=24.
  - The LFSR tap mask 24'hE10000 (bits 23, 22, 21, 16).
  - The non-zero substitute seed 24'h000001.
  - The `FRAME_LEN` default.
- One natural sub-module, `lfsr24_step`, is the combinational one-step next-state function. It is reusable by the receiver-side scheduler and by the testbench model.

## Test plan
- Reset, then 200 `di_en` with no `seed_load` -> `shift_key`=0, `key_valid`=0, `frame_start` never pulses, `sample_idx` stays 0.
- `seed_load` with `seed`=24'h000001 and `scramble_on`=1, then 64 strobes -> on strobe 64: `shift_key`=24'h000087, `key_valid`=1, one `frame_start` pulse.
- `seed`=24'h000000 -> identical behaviour to `seed`=24'h000001 (key 24'h000087 after the first frame).
- `scramble_on` dropped at sample 30 of frame 2 -> key unchanged until the end of frame 2, then 0. Raising it again yields the key for frame 4 per the model, i.e. the LFSR never paused.
- `seed_load` asserted together with `di_en` at `sample_idx`=40 -> `sample_idx`=0, `shift_key`=0, `key_valid`=0, and the next key arrives exactly 64 strobes later.
- `reset` at `sample_idx`=63 together with `di_en` -> no key install, no `frame_start`; all outputs at reset values on the next cycle.
